// File: rtl/ctrl_encode_def.sv
// Shared encodings for the multi-cycle controller: opcodes, functs, datapath selects, FSM states.
package ctrl_encode_def;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;

  localparam logic [1:0] EXT_ZERO   = 2'b00;
  localparam logic [1:0] EXT_SIGNED = 2'b01;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;

  localparam logic [1:0] GPR_RD = 2'b00;
  localparam logic [1:0] GPR_RT = 2'b01;

  typedef enum logic [2:0] {
    StFetch = 3'd0,
    StDcd   = 3'd1,
    StExe   = 3'd2,
    StMem   = 3'd3,
    StWb    = 3'd4
  } state_t;

  // One-hot instruction class; all zero means unsupported.
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic j;
  } instr_t;

endpackage

// File: rtl/multi_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and status in, enables and selects out.
interface multi_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       DMReady;
  logic       PCWr;
  logic       IRWr;
  logic       RFWr;
  logic       DMWr;
  logic [1:0] EXTOp;
  logic [1:0] ALUOp;
  logic [1:0] NPCOp;
  logic       BSel;
  logic [1:0] WDSel;
  logic [1:0] GPRSel;
  logic [2:0] State;

  modport master (
    input  Op, Funct, Zero, DMReady,
    output PCWr, IRWr, RFWr, DMWr, EXTOp, ALUOp, NPCOp, BSel, WDSel, GPRSel, State
  );

  modport slave (
    output Op, Funct, Zero, DMReady,
    input  PCWr, IRWr, RFWr, DMWr, EXTOp, ALUOp, NPCOp, BSel, WDSel, GPRSel, State
  );
endinterface

// File: rtl/ctrl_decode.sv
// Stateless Op/Funct decode into instruction-class flags.
module ctrl_decode
  import ctrl_encode_def::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output instr_t     ic
);

  always_comb begin
    ic = '0;
    case (op)
      OP_RTYPE: begin
        ic.addu = (funct == FUNCT_ADDU);
        ic.subu = (funct == FUNCT_SUBU);
      end
      OP_ORI:  ic.ori = 1'b1;
      OP_LW:   ic.lw  = 1'b1;
      OP_SW:   ic.sw  = 1'b1;
      OP_BEQ:  ic.beq = 1'b1;
      OP_J:    ic.j   = 1'b1;
      default: ic = '0;
    endcase
  end

endmodule

// File: rtl/multi_ctrl.sv
// Multi-cycle MIPS-subset controller: FETCH/DCD/EXE/MEM/WB sequencing and datapath control.
module multi_ctrl
  import ctrl_encode_def::*;
#(
  parameter int unsigned MEM_WAIT_EN = 1
) (
  input logic          clk,
  input logic          rst,
  multi_ctrl_if.master bus
);

  instr_t ic;
  state_t state_q, state_d;
  logic   mem_first_q;

  logic       pc_wr, ir_wr, rf_wr, dm_wr, b_sel;
  logic [1:0] ext_op, alu_op, npc_op, wd_sel, gpr_sel;

  ctrl_decode u_decode (
    .op    (bus.Op),
    .funct (bus.Funct),
    .ic    (ic)
  );

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDcd;
      StDcd:   state_d = (ic.j || ic == '0) ? StFetch : StExe;
      StExe: begin
        if (ic.beq)            state_d = StFetch;
        else if (ic.lw || ic.sw) state_d = StMem;
        else                   state_d = StWb;
      end
      StMem: begin
        if (MEM_WAIT_EN == 0 || bus.DMReady) state_d = ic.lw ? StWb : StFetch;
        else                                 state_d = StMem;
      end
      StWb:    state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFetch;
      mem_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_first_q <= (state_d == StMem) && (state_q != StMem);
    end
  end

  // Outputs follow the current state and the live IR fields, since IR only settles after FETCH.
  always_comb begin
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    rf_wr   = 1'b0;
    dm_wr   = 1'b0;
    b_sel   = 1'b0;
    ext_op  = EXT_ZERO;
    alu_op  = ALU_ADD;
    npc_op  = NPC_PLUS4;
    wd_sel  = WD_ALU;
    gpr_sel = GPR_RD;
    case (state_q)
      StFetch: begin
        ir_wr  = 1'b1;
        pc_wr  = 1'b1;
        npc_op = NPC_PLUS4;
      end
      StDcd: begin
        if (ic.j) begin
          pc_wr  = 1'b1;
          npc_op = NPC_JUMP;
        end
      end
      StExe, StMem, StWb: begin
        // Operand selects are held past EXE so the ALU result stays stable.
        if (ic.subu || ic.beq) alu_op = ALU_SUB;
        if (ic.ori)            alu_op = ALU_OR;
        if (ic.ori || ic.lw || ic.sw)  b_sel  = 1'b1;
        if (ic.lw || ic.sw || ic.beq)  ext_op = EXT_SIGNED;
        if (state_q == StExe && ic.beq) begin
          npc_op = NPC_BRANCH;
          pc_wr  = bus.Zero;
        end
        if (state_q == StMem) dm_wr = ic.sw && mem_first_q;
        if (state_q == StWb) begin
          rf_wr   = 1'b1;
          wd_sel  = ic.lw ? WD_MEM : WD_ALU;
          gpr_sel = (ic.ori || ic.lw) ? GPR_RT : GPR_RD;
        end
      end
      default: ;
    endcase
  end

  // Reset forces every write enable low immediately, independent of the clock.
  assign bus.PCWr   = pc_wr & ~rst;
  assign bus.IRWr   = ir_wr & ~rst;
  assign bus.RFWr   = rf_wr & ~rst;
  assign bus.DMWr   = dm_wr & ~rst;
  assign bus.EXTOp  = ext_op;
  assign bus.ALUOp  = alu_op;
  assign bus.NPCOp  = npc_op;
  assign bus.BSel   = b_sel;
  assign bus.WDSel  = wd_sel;
  assign bus.GPRSel = gpr_sel;
  assign bus.State  = state_q;

endmodule

// File: tb/tb_multi_ctrl.sv
// Directed bench for multi_ctrl: walks each instruction class cycle by cycle with fixed expectations.
module tb_multi_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   dm_pulses = 0;

  multi_ctrl_if bus ();

  multi_ctrl #(
    .MEM_WAIT_EN (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.DMWr === 1'b1) dm_pulses++;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_we(input string tag, input logic [2:0] st, input logic pc, input logic ir,
                        input logic rf, input logic dm);
    chk({tag, ".State"}, 8'(bus.State), 8'(st));
    chk({tag, ".PCWr"},  8'(bus.PCWr),  8'(pc));
    chk({tag, ".IRWr"},  8'(bus.IRWr),  8'(ir));
    chk({tag, ".RFWr"},  8'(bus.RFWr),  8'(rf));
    chk({tag, ".DMWr"},  8'(bus.DMWr),  8'(dm));
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    bus.Op      = 6'b001101;
    bus.Funct   = 6'b000000;
    bus.Zero    = 1'b0;
    bus.DMReady = 1'b1;

    // Held in reset across a clock edge.
    #12;
    chk_we("rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // ori: 0,1,2,4,0
    chk_we("ori_f", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ori_f.NPCOp", 8'(bus.NPCOp), 8'd0);
    cyc(); chk_we("ori_d", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); chk_we("ori_e", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ori_e.EXTOp", 8'(bus.EXTOp), 8'd0);
    chk("ori_e.BSel",  8'(bus.BSel),  8'd1);
    chk("ori_e.ALUOp", 8'(bus.ALUOp), 8'd2);
    cyc(); chk_we("ori_w", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ori_w.GPRSel", 8'(bus.GPRSel), 8'd1);
    chk("ori_w.WDSel",  8'(bus.WDSel),  8'd0);
    chk("ori_w.ALUOp",  8'(bus.ALUOp),  8'd2);
    chk("ori_w.BSel",   8'(bus.BSel),   8'd1);
    cyc(); chk_we("ori_n", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // lw with two wait cycles: 0,1,2,3,3,3,4
    bus.Op = 6'b100011; bus.DMReady = 1'b0;
    cyc(); chk_we("lw_d", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); chk_we("lw_e", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lw_e.EXTOp", 8'(bus.EXTOp), 8'd1);
    chk("lw_e.BSel",  8'(bus.BSel),  8'd1);
    chk("lw_e.ALUOp", 8'(bus.ALUOp), 8'd0);
    cyc(); chk_we("lw_m1", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); chk_we("lw_m2", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); chk_we("lw_m3", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lw_m3.EXTOp", 8'(bus.EXTOp), 8'd1);
    bus.DMReady = 1'b1;
    cyc(); chk_we("lw_w", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("lw_w.WDSel",  8'(bus.WDSel),  8'd1);
    chk("lw_w.GPRSel", 8'(bus.GPRSel), 8'd1);
    chk("lw_w.EXTOp",  8'(bus.EXTOp),  8'd1);
    cyc(); chk_we("lw_n", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // beq taken: 0,1,2,0
    bus.Op = 6'b000100; bus.Zero = 1'b1;
    cyc(); chk_we("beq1_d", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); chk_we("beq1_e", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("beq1_e.NPCOp", 8'(bus.NPCOp), 8'd1);
    chk("beq1_e.ALUOp", 8'(bus.ALUOp), 8'd1);
    chk("beq1_e.EXTOp", 8'(bus.EXTOp), 8'd1);
    chk("beq1_e.BSel",  8'(bus.BSel),  8'd0);
    cyc(); chk_we("beq1_n", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // beq not taken
    bus.Zero = 1'b0;
    cyc(); chk_we("beq0_d", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); chk_we("beq0_e", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("beq0_e.NPCOp", 8'(bus.NPCOp), 8'd1);
    cyc(); chk_we("beq0_n", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // j: 0,1,0
    bus.Op = 6'b000010;
    cyc(); chk_we("j_d", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("j_d.NPCOp", 8'(bus.NPCOp), 8'd2);
    cyc(); chk_we("j_n", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Illegal opcode, then R-type with unsupported funct
    bus.Op = 6'b111111;
    cyc(); chk_we("ill_d", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); chk_we("ill_n", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.Op = 6'b000000; bus.Funct = 6'b000000;
    cyc(); chk_we("fn0_d", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); chk_we("fn0_n", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // subu: 0,1,2,4,0
    bus.Funct = 6'b100011;
    cyc(); chk_we("subu_d", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); chk_we("subu_e", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("subu_e.ALUOp", 8'(bus.ALUOp), 8'd1);
    chk("subu_e.BSel",  8'(bus.BSel),  8'd0);
    cyc(); chk_we("subu_w", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("subu_w.GPRSel", 8'(bus.GPRSel), 8'd0);
    chk("subu_w.WDSel",  8'(bus.WDSel),  8'd0);
    cyc(); chk_we("subu_n", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // sw with reset pulsed mid-cycle during the MEM wait
    bus.Op = 6'b101011; bus.DMReady = 1'b0;
    cyc(); chk_we("sw_d", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); chk_we("sw_e", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sw_e.EXTOp", 8'(bus.EXTOp), 8'd1);
    chk("sw_e.BSel",  8'(bus.BSel),  8'd1);
    cyc(); chk_we("sw_m1", 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(); chk_we("sw_m2", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk_we("sw_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.DMReady = 1'b1;
    #1;
    chk_we("sw_post", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sw.dm_pulses", 8'(dm_pulses), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
